// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: size codes, FSM states and
// byte-lane helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  // Lane where the accessed item starts once offending low bits are dropped.
  function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return addr_lo;
      SZ_HALF: return {addr_lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 4'b0001 << addr_lo;
      SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] addr_lo,
                                          input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {lane_offset(size, addr_lo), 3'b000};
    case (size)
      SZ_BYTE: return {24'd0, shifted[7:0]};
      SZ_HALF: return {16'd0, shifted[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational store-lane replication, byte-enable generation and load extraction.
// With DMEM_MISALIGN_TRAP_EN, misaligned accesses get no byte enables.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [31:0] wr_word,
  output logic [3:0]  byte_en,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic [31:0] rd_val
);

  assign wr_word = replicate(size, wr_data);
  assign rd_val  = extract(size, addr_lo, rd_word);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = misaligned(size, addr_lo);
  assign byte_en  = misalign ? 4'b0000 : byte_enable(size, addr_lo);
`else
  assign byte_en  = byte_enable(size, addr_lo);
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// Wait-stated data-memory controller: one outstanding request, byte-lane RAM.
// Optional misaligned-access trap (err port) under DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mreq,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [1:0]  access_size,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        busy,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic        err,
`endif
  output logic        ack
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [AW+1:0] addr_reg;
  logic [1:0]    size_reg;
  logic          write_reg;
  logic [31:0]   wdata_reg;
  logic [31:0]   rd_data_reg;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic [31:0]   rd_val;
  logic [3:0]    byte_en;
  logic [AW-1:0] rd_idx;
  logic          load_ok;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^addr[31:AW+2];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    busy       = 1'b0;
    ack        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mreq) begin
          busy       = 1'b1;
          cnt_next   = WS_LOAD;
          state_next = (WAIT_STATES > 0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt_reg == 4'd0) state_next = DONE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      DONE: begin
        ack        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Outputs are forced quiet for the whole reset cycle, even mid-access.
    if (rst) begin
      busy = 1'b0;
      ack  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      rd_data_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && mreq) begin
        addr_reg  <= addr[AW+1:0];
        size_reg  <= access_size;
        write_reg <= write;
        wdata_reg <= wr_data;
      end
      if (state_reg == DONE && !write_reg && load_ok) rd_data_reg <= rd_val;
    end
  end

  // The RAM read is registered, so while idle it looks up the incoming address.
  assign rd_idx = (state_reg == IDLE) ? addr[AW+1:2] : addr_reg[AW+1:2];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_byte_reg;
      always_ff @(posedge clk) begin
        if (!rst && state_reg == DONE && write_reg && byte_en[gi])
          mem[addr_reg[AW+1:2]] <= wr_word[8*gi +: 8];
        rd_byte_reg <= mem[rd_idx];
      end
      assign rd_word[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign;
  assign load_ok = !misalign;
  assign err     = ack & misalign;
`else
  assign load_ok = 1'b1;
`endif

  dmem_lane_align u_align (
    .size     (size_reg),
    .addr_lo  (addr_reg[1:0]),
    .wr_data  (wdata_reg),
    .rd_word  (rd_word),
    .wr_word  (wr_word),
    .byte_en  (byte_en),
`ifdef DMEM_MISALIGN_TRAP_EN
    .misalign (misalign),
`endif
    .rd_val   (rd_val)
  );

  assign rd_data = rd_data_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed cases plus random traffic against a
// byte-addressed reference memory; a second instance covers WAIT_STATES=0.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int WS    = 2;
  localparam int DEPTH = 1024;
  localparam int MEMB  = DEPTH * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mreq, write, busy, ack;
  logic [31:0] addr, wr_data, rd_data;
  logic [1:0]  access_size;
  logic        mreq0, write0, busy0, ack0;
  logic [31:0] addr0, wr_data0, rd_data0;
  logic [1:0]  size0;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic err, err0;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0]  model_mem [MEMB];
  logic [31:0] model_rd;

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .rst(rst), .mreq(mreq), .write(write), .addr(addr),
    .access_size(access_size), .wr_data(wr_data), .rd_data(rd_data),
`ifdef DMEM_MISALIGN_TRAP_EN
    .err(err),
`endif
    .busy(busy), .ack(ack)
  );

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .mreq(mreq0), .write(write0), .addr(addr0),
    .access_size(size0), .wr_data(wr_data0), .rd_data(rd_data0),
`ifdef DMEM_MISALIGN_TRAP_EN
    .err(err0),
`endif
    .busy(busy0), .ack(ack0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: byte addresses wrap at the array size; low bits of
  // misaligned halves/words are simply dropped.
  function automatic int eff_addr(input logic [31:0] a, input logic [1:0] sz);
    int base;
    base = int'(a & 32'(MEMB - 1));
    if (sz == 2'd0) return base;
    if (sz == 2'd1) return base & ~1;
    return base & ~3;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] v;
    int e;
    v = 32'd0;
    e = eff_addr(a, sz);
    for (int i = 0; i < nbytes(sz); i++) v = v | (32'(model_mem[e + i]) << (8 * i));
    return v;
  endfunction

  task automatic do_op(input logic w, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] d, input bit verbose);
    bit mis;
    bit got;
    int n;
    int e;
    mis = TRAP && is_mis(a, sz);
    e   = eff_addr(a, sz);
    @(negedge clk);
    mreq = 1'b1; write = w; addr = a; access_size = sz; wr_data = d;
    #1 check("busy_on_request", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    mreq = 1'b0; write = 1'($urandom); addr = $urandom; access_size = 2'($urandom);
    wr_data = $urandom;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ack === 1'b1) got = 1'b1;
      else check("busy_while_waiting", 32'(busy), 32'd1);
    end
    check("ack_latency", 32'(n), 32'(WS + 1));
    check("busy_in_done", 32'(busy), 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("err_with_ack", 32'(err), 32'(mis));
`endif
    if (!mis) begin
      if (w) for (int i = 0; i < nbytes(sz); i++) model_mem[e + i] = d[8*i +: 8];
      else model_rd = model_load(a, sz);
    end
    @(negedge clk);
    check("ack_one_cycle", 32'(ack), 32'd0);
    check("rd_data", rd_data, model_rd);
    if (verbose)
      $display("op %s addr=0x%08h size=%0d data=0x%08h latency=%0d rd_data=0x%08h",
               w ? "store" : "load ", a, sz, d, n, rd_data);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired before the run completed");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prior;
    bit          w0s [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] a0s [5] = '{32'h10, 32'h14, 32'h10, 32'h14, 32'h13};
    logic [1:0]  s0s [5] = '{SZ_WORD, SZ_WORD, SZ_WORD, SZ_WORD, SZ_BYTE};
    logic [31:0] d0s [5] = '{32'h01234567, 32'h89ABCDEF, 32'h0, 32'h0, 32'h0};
    logic [31:0] r0s [5] = '{32'h0, 32'h0, 32'h01234567, 32'h89ABCDEF, 32'h00000001};

    rst = 1'b1; mreq = 1'b1; write = 1'b0; addr = 32'd0; access_size = SZ_WORD; wr_data = 32'd0;
    mreq0 = 1'b1; write0 = 1'b0; addr0 = 32'd0; size0 = SZ_WORD; wr_data0 = 32'd0;
    model_rd = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_busy_ws0", 32'(busy0), 32'd0);
    mreq = 1'b0; mreq0 = 1'b0; rst = 1'b0;
    $display("reset released");

    for (int i = 0; i < DEPTH; i++) do_op(1'b1, 32'(i * 4), SZ_WORD, $urandom, 1'b0);
    $display("array preloaded with %0d words", DEPTH);

    do_op(1'b1, 32'h100, SZ_WORD, 32'hDEADBEEF, 1'b1);
    do_op(1'b0, 32'h100, SZ_WORD, 32'h0, 1'b1);
    check("word_roundtrip", rd_data, 32'hDEADBEEF);

    do_op(1'b1, 32'h200, SZ_BYTE, 32'h11, 1'b1);
    do_op(1'b1, 32'h201, SZ_BYTE, 32'h22, 1'b1);
    do_op(1'b1, 32'h202, SZ_BYTE, 32'h33, 1'b1);
    do_op(1'b1, 32'h203, SZ_BYTE, 32'h44, 1'b1);
    do_op(1'b0, 32'h200, SZ_WORD, 32'h0, 1'b1);
    check("bytes_as_word", rd_data, 32'h44332211);
    do_op(1'b0, 32'h203, SZ_BYTE, 32'h0, 1'b1);
    check("byte_load_lane3", rd_data, 32'h00000044);
    do_op(1'b0, 32'h202, SZ_HALF, 32'h0, 1'b1);
    check("half_load_upper", rd_data, 32'h00004433);
    do_op(1'b1, 32'h206, SZ_HALF, 32'hFFFF_BEEF, 1'b1);
    do_op(1'b0, 32'h204, SZ_WORD, 32'h0, 1'b1);

    do_op(1'b1, 32'h302, SZ_WORD, 32'h12345678, 1'b1);
    do_op(1'b0, 32'h300, SZ_WORD, 32'h0, 1'b1);
    if (!TRAP) check("misaligned_word_store", rd_data, 32'h12345678);
    do_op(1'b0, 32'h103, SZ_HALF, 32'h0, 1'b1);

    do_op(1'b1, 32'h1000, SZ_WORD, 32'hA5A51234, 1'b1);
    do_op(1'b0, 32'h0, SZ_WORD, 32'h0, 1'b1);
    check("alias_wrap", rd_data, 32'hA5A51234);

    // Reset in the WAIT cycle of a store must abort it without writing.
    prior = model_load(32'h40, SZ_WORD);
    @(negedge clk);
    mreq = 1'b1; write = 1'b1; addr = 32'h40; access_size = SZ_WORD; wr_data = 32'hCAFEF00D;
    @(posedge clk);
    #1 mreq = 1'b0;
    @(negedge clk);
    rst = 1'b1; mreq = 1'b1;
    #1 check("rst_in_wait_busy", 32'(busy), 32'd0);
    check("rst_in_wait_ack", 32'(ack), 32'd0);
    @(negedge clk);
    rst = 1'b0; mreq = 1'b0; model_rd = 32'd0;
    check("after_abort_busy", 32'(busy), 32'd0);
    check("after_abort_ack", 32'(ack), 32'd0);
    check("after_abort_rd_data", rd_data, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_late_ack", 32'(ack), 32'd0);
    end
    $display("reset during WAIT of store 0xCAFEF00D at 0x40");
    do_op(1'b0, 32'h40, SZ_WORD, 32'h0, 1'b1);
    check("aborted_store_no_write", rd_data, prior);

    repeat (300) do_op(1'($urandom), $urandom, 2'($urandom), $urandom, 1'b1);

    // Zero-wait-state instance with mreq held high across back-to-back requests.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k > 0) check("ws0_rd_data", rd_data0, r0s[k-1]);
      mreq0 = 1'b1; write0 = w0s[k]; addr0 = a0s[k]; size0 = s0s[k]; wr_data0 = d0s[k];
      #1 check("ws0_busy_accept", 32'(busy0), 32'd1);
      check("ws0_ack_accept", 32'(ack0), 32'd0);
      @(negedge clk);
      check("ws0_busy_done", 32'(busy0), 32'd0);
      check("ws0_ack_done", 32'(ack0), 32'd1);
`ifdef DMEM_MISALIGN_TRAP_EN
      check("ws0_err", 32'(err0), 32'd0);
`endif
      $display("ws0 op %s addr=0x%08h size=%0d data=0x%08h", w0s[k] ? "store" : "load ",
               a0s[k], s0s[k], d0s[k]);
    end
    @(negedge clk);
    mreq0 = 1'b0;
    #1 check("ws0_rd_data_last", rd_data0, r0s[4]);
    check("ws0_idle_busy", 32'(busy0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
